// File: rtl/ram8bit_bist.sv
// ram8bit_bist -- march-style self-test initiator for a small single-port RAM.
//
// On an accepted start the block runs four phases against the RAM port:
// write P(a) = seed + a, read back and verify, write ~P(a), read back and
// verify. It then reports pass/fail, a saturating error count, and the
// address and data of the first mismatching read.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-low reset
//   start            begin a test; honoured only in IDLE or DONE
//   seed             pattern seed, captured when start is accepted
//   mem_addr         RAM address (0 outside write/read phases)
//   mem_data         RAM write data (0 whenever mem_wr is low)
//   mem_wr, mem_rd   RAM strobes, never high together
//   mem_out          RAM read data, valid the cycle after mem_rd
//   busy             high while the test runs
//   done             high from completion until the next start or reset
//   pass             valid with done; 1 when no mismatches were seen
//   err_count        mismatch count, saturating at 15
//   first_fail_addr  address of the first mismatch
//   first_fail_data  data read at the first mismatch
//
// RAM handshake: there is no ready; the RAM accepts mem_wr/mem_rd in the cycle
// they are high, and mem_out answers a read exactly one cycle later.
module ram8bit_bist #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        err_count,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_data
);

  typedef enum logic [2:0] {
    IDLE, WR1, RD1, CHK1, WR2, RD2, CHK2, DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] seed_q, seed_d;

  // Read pipeline: expected word and address of the read issued last cycle.
  logic              chk_q, chk_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;

  // Next values of the registered outputs.
  logic              wr_d, rd_d, busy_d, done_d, pass_d;
  logic [DATA_W-1:0] data_d;
  logic [3:0]        err_d;
  logic [ADDR_W-1:0] ffa_d;
  logic [DATA_W-1:0] ffd_d;
  logic              accept, mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    return s + {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign mismatch = chk_q && (mem_out != exp_q);

  // State register and all output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      seed_q          <= '0;
      mem_addr        <= '0;
      mem_data        <= '0;
      mem_wr          <= 1'b0;
      mem_rd          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
      chk_q           <= 1'b0;
      exp_q           <= '0;
      chk_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      seed_q          <= seed_d;
      mem_addr        <= addr_d;
      mem_data        <= data_d;
      mem_wr          <= wr_d;
      mem_rd          <= rd_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_count       <= err_d;
      first_fail_addr <= ffa_d;
      first_fail_data <= ffd_d;
      chk_q           <= chk_d;
      exp_q           <= exp_d;
      chk_addr_q      <= chk_addr_d;
    end
  end

  // Next-state and address sequencing. The address falls back to 0 on
  // every phase change and outside the write/read phases.
  always_comb begin
    state_d = state_q;
    addr_d  = '0;
    seed_d  = seed_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WR1;
          seed_d  = seed;
        end
      end
      WR1:  if (mem_addr == ADDR_LAST) state_d = RD1;  else addr_d = mem_addr + 1'b1;
      RD1:  if (mem_addr == ADDR_LAST) state_d = CHK1; else addr_d = mem_addr + 1'b1;
      CHK1: state_d = WR2;
      WR2:  if (mem_addr == ADDR_LAST) state_d = RD2;  else addr_d = mem_addr + 1'b1;
      RD2:  if (mem_addr == ADDR_LAST) state_d = CHK2; else addr_d = mem_addr + 1'b1;
      CHK2: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and the compare
  // pipeline.
  always_comb begin
    wr_d   = (state_d == WR1) || (state_d == WR2);
    rd_d   = (state_d == RD1) || (state_d == RD2);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);

    data_d = '0;
    if (state_d == WR1) data_d = pattern(seed_d, addr_d);
    if (state_d == WR2) data_d = ~pattern(seed_d, addr_d);

    // Expected word for the read being presented this cycle.
    chk_d      = mem_rd;
    chk_addr_d = mem_addr;
    exp_d      = '0;
    if (state_q == RD1) exp_d = pattern(seed_q, mem_addr);
    if (state_q == RD2) exp_d = ~pattern(seed_q, mem_addr);

    err_d = err_count;
    ffa_d = first_fail_addr;
    ffd_d = first_fail_data;
    if (accept) begin
      err_d = '0;
      ffa_d = '0;
      ffd_d = '0;
    end else if (mismatch) begin
      // A zero count before this compare means this is the first mismatch.
      if (err_count == 4'd0) begin
        ffa_d = chk_addr_q;
        ffd_d = mem_out;
      end
      if (err_count != 4'd15) err_d = err_count + 4'd1;
    end

    pass_d = done_d && (err_d == 4'd0);
  end

endmodule

// File: tb/tb_ram8bit_bist.sv
// tb_ram8bit_bist -- self-checking bench for ram8bit_bist with a behavioural
// RAM that can inject stuck-at faults or a fixed read bus.
module tb_ram8bit_bist;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_wr;
  logic       mem_rd;
  logic [7:0] mem_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_addr;
  logic [7:0] first_fail_data;

  int n_cmp = 0;
  int n_err = 0;

  // RAM fault setup: 0 ideal, 1 stuck-at-0, 2 bus fixed at 55, 3 stuck-at-1.
  int         fault_mode = 0;
  logic [2:0] fault_addr = 3'd0;
  logic [7:0] fault_mask = 8'h00;

  logic [7:0]  ram [8];
  logic [7:0]  ram_q;
  logic [14:0] exp_q[$];

  ram8bit_bist #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_out(mem_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr),
    .first_fail_data(first_fail_data)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a read of address a returns when word v is stored there.
  function automatic logic [7:0] faulty(input logic [7:0] v, input logic [2:0] a);
    case (fault_mode)
      1:       return (a == fault_addr) ? (v & ~fault_mask) : v;
      2:       return 8'h55;
      3:       return (a == fault_addr) ? (v | fault_mask) : v;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_data;
    if (mem_rd) ram_q <= faulty(ram[mem_addr], mem_addr);
  end
  assign mem_out = ram_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected RAM-side bus in busy cycle c after the start edge:
  // {busy, done, wr, rd, addr, data}.
  function automatic logic [14:0] bus_word(input int c, input logic [7:0] s);
    logic       wr, rd;
    logic [2:0] a;
    logic [7:0] d;
    wr = 1'b0; rd = 1'b0; a = 3'd0; d = 8'h00;
    if (c < 8) begin
      wr = 1'b1; a = 3'(c); d = s + 8'(c);
    end else if (c < 16) begin
      rd = 1'b1; a = 3'(c - 8);
    end else if (c >= 17 && c < 25) begin
      wr = 1'b1; a = 3'(c - 17); d = ~(s + 8'(c - 17));
    end else if (c >= 25 && c < 33) begin
      rd = 1'b1; a = 3'(c - 25);
    end
    return {1'b1, 1'b0, wr, rd, a, d};
  endfunction

  // Whole-test outcome: every word written is read back through the faulty RAM.
  task automatic expect_results(input logic [7:0] s, output logic [3:0] errs,
                                output logic [2:0] ffa, output logic [7:0] ffd);
    logic [7:0] v, r;
    errs = 4'd0; ffa = 3'd0; ffd = 8'h00;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 8; a++) begin
        v = s + 8'(a);
        if (p == 1) v = ~v;
        r = faulty(v, 3'(a));
        if (r != v) begin
          if (errs == 4'd0) begin
            ffa = 3'(a);
            ffd = r;
          end
          if (errs != 4'd15) errs = errs + 4'd1;
        end
      end
    end
  endtask

  function automatic logic [30:0] all_outputs();
    return {busy, done, pass, err_count, first_fail_addr, first_fail_data,
            mem_wr, mem_rd, mem_addr, mem_data};
  endfunction

  // Driver: one test run. repulse_at / reset_at give the edge offset from the
  // start edge at which start is re-pulsed / rst is asserted (-1 = never).
  task automatic run_test(input logic [7:0] s, input int repulse_at, input int reset_at);
    logic [3:0] errs;
    logic [2:0] ffa;
    logic [7:0] ffd;
    logic [14:0] e;
    @(negedge clk);
    start = 1'b1;
    seed  = s;
    exp_q.delete();
    for (int c = 0; c < 34; c++) exp_q.push_back(bus_word(c, s));
    expect_results(s, errs, ffa, ffd);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      if (c == reset_at) begin
        check("rst_mid", 32'(all_outputs()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_idle", 32'(all_outputs()), 32'd0);
        return;
      end
      e = exp_q.pop_front();
      check("cyc", 32'({busy, done, mem_wr, mem_rd, mem_addr, mem_data}), 32'(e));
      if (c == 0)
        check("clr", 32'({pass, err_count, first_fail_addr, first_fail_data}), 32'd0);
      start = (c == repulse_at - 1);
      seed  = 8'($urandom);
      if (c == reset_at - 1) rst = 1'b0;
    end
    @(negedge clk);
    check("done_bus", 32'({busy, done, mem_wr, mem_rd, mem_addr, mem_data}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00}));
    check("result", 32'({pass, err_count, first_fail_addr, first_fail_data}),
          32'({errs == 4'd0, errs, ffa, ffd}));
    repeat ($urandom_range(1, 3)) @(negedge clk);
    check("hold", 32'({busy, done, pass, err_count, first_fail_addr, first_fail_data}),
          32'({1'b0, 1'b1, errs == 4'd0, errs, ffa, ffd}));
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    seed  = 8'($urandom);

    // Reset holds everything at zero even with start high.
    @(negedge clk);
    @(negedge clk);
    check("reset0", 32'(all_outputs()), 32'd0);
    @(negedge clk);
    check("reset1", 32'(all_outputs()), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal RAM, seed 00 and wrapping seed FE.
    fault_mode = 0;
    run_test(8'h00, -1, -1);
    run_test(8'hFE, -1, -1);

    // Bit 3 stuck-at-0 at address 5: only the inverse phase fails (F2 vs FA).
    fault_mode = 1; fault_addr = 3'd5; fault_mask = 8'h08;
    run_test(8'h00, -1, -1);
    check("sa0_count", 32'(err_count), 32'd1);
    check("sa0_data", 32'(first_fail_data), 32'hF2);

    // Read bus stuck at 55: every compare fails, count saturates.
    fault_mode = 2;
    run_test(8'h00, -1, -1);
    check("sat_count", 32'(err_count), 32'd15);

    // Control edges: ignored re-pulse, then reset mid-test, then a clean run.
    fault_mode = 0;
    run_test(8'($urandom), 5, -1);
    run_test(8'($urandom), 5, 12);
    run_test(8'($urandom), -1, -1);
    check("fresh_pass", 32'(pass), 32'd1);

    // Randomized seeds and fault locations.
    for (int i = 0; i < 12; i++) begin
      fault_mode = int'($urandom_range(0, 3));
      fault_addr = 3'($urandom_range(0, 7));
      fault_mask = 8'(1 << $urandom_range(0, 7));
      run_test(8'($urandom), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
